// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment square display animators.
package sseg_pkg;

    localparam int POS_W   = 3;
    localparam int NUM_POS = 8;

    typedef enum logic {
        S_STOP,
        S_RUN
    } gen_state_t;

    // Next slot around the square loop; the 3-bit wrap gives modulo-8 arithmetic.
    function automatic logic [POS_W-1:0] pos_step(input logic [POS_W-1:0] pos,
                                                 input logic             cw);
        return cw ? pos + POS_W'(1) : pos - POS_W'(1);
    endfunction

endpackage

// File: rtl/square_pattern_gen_tick_gen.sv
// Prescaler: counts 0..limit-1 and flags the terminal cycle. The terminal test
// is count+1 >= limit, so a count already beyond a freshly lowered limit ticks
// on the next edge instead of running on to wrap.
module tick_gen #(
    parameter int CNT_W = 3,
    parameter int LIM_W = CNT_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [LIM_W-1:0] limit,
    output logic             tick
);

    logic [CNT_W-1:0] count;
    logic [LIM_W-1:0] count_inc;

    assign count_inc = {1'b0, count} + LIM_W'(1);
    assign tick      = !clr && (count_inc >= limit);

    // Count up, restarting at zero on a clear or at the terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/square_pattern_gen.sv
// Position generator for the square decoder: walks the eight square slots
// clockwise or counter-clockwise, either free-running at a programmable rate
// or one slot per step pulse while stopped.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_STOP | prescaler held at 0; each cycle with step=1 advances pos
//   S_RUN  | pos advances on every prescaler terminal count; step ignored
module square_pattern_gen
    import sseg_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cw,
    input  logic [1:0]       speed,
    input  logic             step,
    output logic [POS_W-1:0] pos,
    output logic             adv,
    output logic             lap
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int LIM_W = CNT_W + 1;
    // One extra bit so limit can hold TICK_DIV itself at speed 0.
    localparam logic [LIM_W-1:0] DIV = LIM_W'(TICK_DIV);

    gen_state_t       state;
    logic [LIM_W-1:0] limit;
    logic             clr;
    logic             tick;
    logic [POS_W-1:0] pos_next;

    assign limit    = DIV >> speed;
    // Clearing when en drops also suppresses a tick that lands on the stop edge.
    assign clr      = (state == S_STOP) || !en;
    assign pos_next = pos_step(pos, cw);

    tick_gen #(
        .CNT_W (CNT_W),
        .LIM_W (LIM_W)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .limit (limit),
        .tick  (tick)
    );

    // Run/stop FSM with the position register and registered pulse outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_STOP;
            pos   <= '0;
            adv   <= 1'b0;
            lap   <= 1'b0;
        end else begin
            adv <= 1'b0;
            lap <= 1'b0;
            unique case (state)
                S_STOP: begin
                    if (step) begin
                        pos <= pos_next;
                        adv <= 1'b1;
                        lap <= (pos_next == '0);
                    end
                    if (en) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!en) begin
                        state <= S_STOP;
                    end else if (tick) begin
                        pos <= pos_next;
                        adv <= 1'b1;
                        lap <= (pos_next == '0);
                    end
                end
                default: begin
                    state <= S_STOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_square_pattern_gen.sv
// Scoreboard bench for square_pattern_gen with TICK_DIV = 8.
module tb_square_pattern_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       cw;
    logic [1:0] speed;
    logic       step;
    logic [2:0] pos;
    logic       adv;
    logic       lap;

    square_pattern_gen #(.TICK_DIV(8)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .cw    (cw),
        .speed (speed),
        .step  (step),
        .pos   (pos),
        .adv   (adv),
        .lap   (lap)
    );

    always #5 clk = ~clk;

    // Rising-edge count; an advance made on edge N is seen at the negedge where cyc == N.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [2:0] p;
        logic       l;
    } exp_t;

    exp_t sbq[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic chk(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int c, input int p);
        exp_t e;
        e.c = c;
        e.p = 3'(p);
        e.l = (p == 0);
        sbq.push_back(e);
    endtask

    // Monitor: every advance must match the head of the queue; otherwise pos holds and lap stays low.
    logic [2:0] prev_pos = '0;
    always @(negedge clk) begin
        if (reset) begin
            prev_pos = pos;
        end else begin
            if (adv) begin
                if (sbq.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_adv: got adv=1 pos=%0d, expected no advance (cycle %0d)", pos, cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("adv_cycle", cyc, e.c);
                    chk("adv_pos", int'(pos), int'(e.p));
                    chk("adv_lap", int'(lap), int'(e.l));
                end
            end else begin
                chk("idle_lap", int'(lap), 0);
                chk("idle_pos_hold", int'(pos), int'(prev_pos));
            end
            prev_pos = pos;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        int t;
        int c;
        int r;

        reset = 1'b1;
        en    = 1'b0;
        cw    = 1'b1;
        speed = 2'd0;
        step  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pos", int'(pos), 0);
        chk("rst_adv", int'(adv), 0);
        chk("rst_lap", int'(lap), 0);
        reset = 1'b0;
        @(negedge clk);

        // Clockwise lap at speed 0: first advance 8 edges after en is sampled.
        en = 1'b1;
        e0 = cyc + 1;
        push(e0 + 8,  1); push(e0 + 16, 2); push(e0 + 24, 3); push(e0 + 32, 4);
        push(e0 + 40, 5); push(e0 + 48, 6); push(e0 + 56, 7); push(e0 + 64, 0);
        repeat (65) @(negedge clk);

        // Counter-clockwise lap continuing from pos 0.
        cw = 1'b0;
        push(e0 + 72,  7); push(e0 + 80,  6); push(e0 + 88,  5); push(e0 + 96,  4);
        push(e0 + 104, 3); push(e0 + 112, 2); push(e0 + 120, 1); push(e0 + 128, 0);
        repeat (64) @(negedge clk);

        // Speed 2 (limit 2), then speed 3 (limit 1) while count is 1.
        t     = cyc;
        cw    = 1'b1;
        speed = 2'd2;
        push(t + 2, 1); push(t + 4, 2); push(t + 6, 3);
        repeat (7) @(negedge clk);
        speed = 2'd3;
        push(t + 8, 4); push(t + 9, 5); push(t + 10, 6); push(t + 11, 7); push(t + 12, 0);
        repeat (5) @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        speed = 2'd0;

        // Step pulses while stopped: single, held for three cycles, single.
        c = cyc; step = 1'b1; push(c + 1, 1);
        @(negedge clk); step = 1'b0; @(negedge clk);
        c = cyc; step = 1'b1; push(c + 1, 2); push(c + 2, 3); push(c + 3, 4);
        repeat (3) @(negedge clk); step = 1'b0; @(negedge clk);
        c = cyc; step = 1'b1; push(c + 1, 5);
        @(negedge clk); step = 1'b0; @(negedge clk);
        chk("pos_at_5", int'(pos), 5);
        c = cyc; step = 1'b1; push(c + 1, 6);
        @(negedge clk); step = 1'b0; @(negedge clk);
        c = cyc; step = 1'b1; push(c + 1, 7);
        @(negedge clk); step = 1'b0; @(negedge clk);
        c = cyc; step = 1'b1; push(c + 1, 0);
        @(negedge clk); step = 1'b0; @(negedge clk);

        // en and step together: step honoured, then run; a step during run is ignored.
        c    = cyc;
        en   = 1'b1;
        step = 1'b1;
        push(c + 1, 1); push(c + 9, 2); push(c + 17, 3);
        @(negedge clk); step = 1'b0;
        repeat (3) @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        repeat (15) @(negedge clk);

        // Reset mid-count at pos 3.
        chk("pos_before_reset", int'(pos), 3);
        chk("pending_before_reset", sbq.size(), 0);
        reset = 1'b1;
        #1;
        chk("async_rst_pos", int'(pos), 0);
        chk("async_rst_adv", int'(adv), 0);
        chk("async_rst_lap", int'(lap), 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        r = cyc;
        push(r + 9, 1);
        repeat (16) @(negedge clk);

        // Drop en on the terminal-count edge: no advance, then a full period after re-enable.
        en = 1'b0;
        repeat (2) @(negedge clk);
        chk("pos_after_stop", int'(pos), 1);
        en = 1'b1;
        push(r + 27, 2); push(r + 35, 3);
        repeat (20) @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        chk("final_pos", int'(pos), 3);
        chk("queue_empty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
